// File: rtl/dds_rom_scheduler_pkg.sv
// Purpose: shared DDS definitions (default widths, FSM encoding, channel indices).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dds_rom_scheduler_pkg;

    localparam int ACC_BIT_DEF           = 32;
    localparam int ROM_PHASE_BIT_DEF     = 10;
    localparam int ROM_AMPLITUDE_BIT_DEF = 12;

    // Channel indices used on ftw_ch
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // A frame is SLOT_A followed by SLOT_B; IDLE parks the sequencer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } state_t;

endpackage

// File: rtl/dds_rom_scheduler_phase_acc.sv
// Purpose: one DDS channel: phase accumulator, active/shadow tuning word, pending flag.
// Latency: shadow load 1 clk; shadow->active copy on commit; accumulator steps on step.
// Backpressure: caller must only load while pending is low (pending drives the ready).
// Ports: clk/rst (sync, active-low); step adds active ftw; clear zeroes the accumulator
//        (wins over step); commit copies a pending shadow; load/load_data write the shadow;
//        pending flags an uncommitted shadow; phase_next is the top ROM_PHASE_BIT bits of the
//        accumulator value after this edge.
module dds_phase_acc
    import dds_rom_scheduler_pkg::*;
#(
    parameter int ACC_BIT       = ACC_BIT_DEF,
    parameter int ROM_PHASE_BIT = ROM_PHASE_BIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic                     clear,
    input  logic                     commit,
    input  logic                     load,
    input  logic [ACC_BIT-1:0]       load_data,
    output logic                     pending,
    output logic [ROM_PHASE_BIT-1:0] phase_next
);

    logic [ACC_BIT-1:0] acc;
    logic [ACC_BIT-1:0] acc_next;
    logic [ACC_BIT-1:0] ftw_active;
    logic [ACC_BIT-1:0] ftw_shadow;

    // The add always uses the active word as it stood before this edge, so a
    // commit on the same edge only affects the following frame.
    always_comb begin
        acc_next = acc;
        if (clear) begin
            acc_next = '0;
        end else if (step) begin
            acc_next = acc + ftw_active;
        end
    end

    assign phase_next = acc_next[ACC_BIT-1 -: ROM_PHASE_BIT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            ftw_active <= '0;
            ftw_shadow <= '0;
            pending    <= 1'b0;
        end else begin
            acc <= acc_next;
            if (commit && pending) begin
                ftw_active <= ftw_shadow;
            end
            if (load) begin
                ftw_shadow <= load_data;
            end
            // A load in the same cycle as a commit re-arms pending for the next frame.
            if (load) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dds_rom_scheduler.sv
// Purpose: two-channel DDS time-sharing one registered sine ROM (SLOT_A then SLOT_B per frame).
// Latency: rom_phase valid in the slot cycle; sample_x/sample_x_valid 2 clk after slot entry.
// Backpressure: ftw_ready low while that channel already holds an uncommitted word.
// Ports: clk, rst (sync, active-low), run, phase_clr, ftw_valid/ftw_ready/ftw_ch/ftw_data,
//        rom_phase -> ROM, rom_value <- ROM (1 clk later), sample_a/b + sample_a/b_valid.
// Option: define DDS_SCHED_PHASE_OFFSET_EN to add offset_a/offset_b phase offsets.
module dds_rom_scheduler
    import dds_rom_scheduler_pkg::*;
#(
    parameter int ACC_BIT           = ACC_BIT_DEF,
    parameter int ROM_PHASE_BIT     = ROM_PHASE_BIT_DEF,   // must not exceed ACC_BIT
    parameter int ROM_AMPLITUDE_BIT = ROM_AMPLITUDE_BIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         phase_clr,
    input  logic                         ftw_valid,
    output logic                         ftw_ready,
    input  logic                         ftw_ch,
    input  logic [ACC_BIT-1:0]           ftw_data,
`ifdef DDS_SCHED_PHASE_OFFSET_EN
    input  logic [ROM_PHASE_BIT-1:0]     offset_a,
    input  logic [ROM_PHASE_BIT-1:0]     offset_b,
`endif
    output logic [ROM_PHASE_BIT-1:0]     rom_phase,
    input  logic [ROM_AMPLITUDE_BIT-1:0] rom_value,
    output logic [ROM_AMPLITUDE_BIT-1:0] sample_a,
    output logic [ROM_AMPLITUDE_BIT-1:0] sample_b,
    output logic                         sample_a_valid,
    output logic                         sample_b_valid
);

    state_t state, state_nxt;
    state_t state_d1;          // slot whose ROM data is on rom_value this cycle

    logic                     clr_seen;
    logic                     frame_end;
    logic                     commit;
    logic                     acc_clear;
    logic                     pend_a, pend_b;
    logic                     load_a, load_b;
    logic [ROM_PHASE_BIT-1:0] phase_a, phase_b;
    logic [ROM_PHASE_BIT-1:0] addr_a, addr_b;
    logic [ROM_PHASE_BIT-1:0] rom_phase_d;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = SLOT_A;
            SLOT_A:  state_nxt = SLOT_B;
            SLOT_B:  state_nxt = run ? SLOT_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- frame control ----------------
    assign frame_end = (state == SLOT_B);
    // Shadows are copied at every frame boundary, or straight away while parked.
    assign commit    = frame_end || (state == IDLE);
    // A clear request latched during the frame (or arriving in SLOT_B itself)
    // replaces the boundary add; while parked it acts on the next edge.
    assign acc_clear = (state == IDLE) ? phase_clr : (frame_end && (clr_seen || phase_clr));

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_seen <= 1'b0;
        end else if (state == SLOT_A) begin
            clr_seen <= clr_seen | phase_clr;
        end else begin
            clr_seen <= 1'b0;
        end
    end

    // ---------------- tuning word handshake ----------------
    assign ftw_ready = (ftw_ch == CH_B) ? !pend_b : !pend_a;
    assign load_a    = ftw_valid && ftw_ready && (ftw_ch == CH_A);
    assign load_b    = ftw_valid && ftw_ready && (ftw_ch == CH_B);

    dds_phase_acc #(
        .ACC_BIT       (ACC_BIT),
        .ROM_PHASE_BIT (ROM_PHASE_BIT)
    ) u_acc_a (
        .clk        (clk),
        .rst        (rst),
        .step       (frame_end),
        .clear      (acc_clear),
        .commit     (commit),
        .load       (load_a),
        .load_data  (ftw_data),
        .pending    (pend_a),
        .phase_next (phase_a)
    );

    dds_phase_acc #(
        .ACC_BIT       (ACC_BIT),
        .ROM_PHASE_BIT (ROM_PHASE_BIT)
    ) u_acc_b (
        .clk        (clk),
        .rst        (rst),
        .step       (frame_end),
        .clear      (acc_clear),
        .commit     (commit),
        .load       (load_b),
        .load_data  (ftw_data),
        .pending    (pend_b),
        .phase_next (phase_b)
    );

    // ---------------- ROM address ----------------
`ifdef DDS_SCHED_PHASE_OFFSET_EN
    assign addr_a = phase_a + offset_a;   // wraps modulo 2^ROM_PHASE_BIT
    assign addr_b = phase_b + offset_b;
`else
    assign addr_a = phase_a;
    assign addr_b = phase_b;
`endif

    // rom_phase is registered from the next-state view so that it already
    // carries the slot's address during the slot cycle itself.
    always_comb begin
        rom_phase_d = rom_phase;
        if (state_nxt == SLOT_A) begin
            rom_phase_d = addr_a;
        end else if (state_nxt == SLOT_B) begin
            rom_phase_d = addr_b;
        end
    end

    // ---------------- sample capture ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_phase      <= '0;
            state_d1       <= IDLE;
            sample_a       <= '0;
            sample_b       <= '0;
            sample_a_valid <= 1'b0;
            sample_b_valid <= 1'b0;
        end else begin
            rom_phase      <= rom_phase_d;
            state_d1       <= state;
            sample_a_valid <= (state_d1 == SLOT_A);
            sample_b_valid <= (state_d1 == SLOT_B);
            if (state_d1 == SLOT_A) begin
                sample_a <= rom_value;
            end
            if (state_d1 == SLOT_B) begin
                sample_b <= rom_value;
            end
        end
    end

endmodule

// File: tb/tb_dds_rom_scheduler.sv
// Purpose: randomized + directed bench for dds_rom_scheduler against a frame-level model.
// Latency: model predicts ROM address per slot; sample expected 2 clk after slot entry.
// Backpressure: ftw writes retry until the model says the channel has room.
module tb_dds_rom_scheduler;

    localparam int AW = 32;
    localparam int PW = 10;
    localparam int VW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          phase_clr = 1'b0;
    logic          ftw_valid = 1'b0;
    logic          ftw_ready;
    logic          ftw_ch = 1'b0;
    logic [AW-1:0] ftw_data = '0;
    logic [PW-1:0] rom_phase;
    logic [VW-1:0] rom_value = '0;
    logic [VW-1:0] sample_a, sample_b;
    logic          sample_a_valid, sample_b_valid;
`ifdef DDS_SCHED_PHASE_OFFSET_EN
    logic [PW-1:0] offset_a = '0;
    logic [PW-1:0] offset_b = '0;
`endif

    always #5 clk = ~clk;

    dds_rom_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .phase_clr      (phase_clr),
        .ftw_valid      (ftw_valid),
        .ftw_ready      (ftw_ready),
        .ftw_ch         (ftw_ch),
        .ftw_data       (ftw_data),
`ifdef DDS_SCHED_PHASE_OFFSET_EN
        .offset_a       (offset_a),
        .offset_b       (offset_b),
`endif
        .rom_phase      (rom_phase),
        .rom_value      (rom_value),
        .sample_a       (sample_a),
        .sample_b       (sample_b),
        .sample_a_valid (sample_a_valid),
        .sample_b_valid (sample_b_valid)
    );

    // Registered ROM whose content equals its address.
    always @(posedge clk) rom_value <= VW'(rom_phase);

    // ---------------- reference model ----------------
    typedef struct { bit ch; logic [VW-1:0] val; } exp_t;
    exp_t        sbq[$];
    int          checks = 0;
    int          fails  = 0;

    int          mst = 0;               // 0 parked, 1 slot A, 2 slot B
    logic [AW-1:0] macc[2] = '{32'd0, 32'd0};
    logic [AW-1:0] mftw[2] = '{32'd0, 32'd0};
    logic [AW-1:0] mshd[2] = '{32'd0, 32'd0};
    bit          mpend[2] = '{1'b0, 1'b0};
    bit          mclr = 1'b0;
    logic [PW-1:0] mrom = '0;
    bit          rst_chk = 1'b0;
    bit          run_lvl = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] slot_addr(input int ch);
        int off = 0;
`ifdef DDS_SCHED_PHASE_OFFSET_EN
        off = (ch == 0) ? int'(offset_a) : int'(offset_b);
`endif
        return PW'((macc[ch] >> (AW - PW)) + off);
    endfunction

    // Apply the scheduler rules for one rising edge using the inputs now on the pins.
    task automatic model_edge();
        int   nxt;
        bit   fire;
        exp_t e;
        if (!rst) begin
            mst = 0; mclr = 0; mrom = '0; rst_chk = 1;
            for (int i = 0; i < 2; i++) begin
                macc[i] = 0; mftw[i] = 0; mshd[i] = 0; mpend[i] = 0;
            end
            sbq.delete();
            return;
        end
        fire = ftw_valid && !mpend[ftw_ch];
        nxt  = mst;
        if (mst == 1) begin
            if (phase_clr) mclr = 1;
            nxt = 2;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mst == 0) begin
                    if (phase_clr) macc[i] = 0;
                end else if (mclr || phase_clr) begin
                    macc[i] = 0;
                end else begin
                    macc[i] = macc[i] + mftw[i];
                end
                if (mpend[i]) begin
                    mftw[i] = mshd[i];
                    mpend[i] = 0;
                end
            end
            mclr = 0;
            nxt = run ? 1 : 0;
        end
        if (fire) begin
            mshd[ftw_ch]  = ftw_data;
            mpend[ftw_ch] = 1;
        end
        mst = nxt;
        if (nxt != 0) begin
            mrom  = slot_addr(nxt - 1);
            e.ch  = (nxt == 2);
            e.val = VW'(mrom);
            sbq.push_back(e);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sample_a_valid) begin
            if (sbq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_sample_a_valid actual=1 expected=0 at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("valid_chan_a", 32'd0, {31'd0, e.ch});
                chk("sample_a", {20'd0, sample_a}, {20'd0, e.val});
            end
        end
        if (sample_b_valid) begin
            if (sbq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_sample_b_valid actual=1 expected=0 at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("valid_chan_b", 32'd1, {31'd0, e.ch});
                chk("sample_b", {20'd0, sample_b}, {20'd0, e.val});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rn, input bit r, input bit pc,
                        input bit fv, input bit fch, input logic [AW-1:0] fd);
        rst = rn; run = r; phase_clr = pc;
        ftw_valid = fv; ftw_ch = fch; ftw_data = fd;
        @(negedge clk);
        chk("ftw_ready", {31'd0, ftw_ready}, {31'd0, !mpend[fch]});
        chk("rom_phase", {22'd0, rom_phase}, {22'd0, mrom});
        if (rst_chk) begin
            rst_chk = 0;
            chk("rst_sample_a", {20'd0, sample_a}, 32'd0);
            chk("rst_sample_b", {20'd0, sample_b}, 32'd0);
            chk("rst_valids", {30'd0, sample_a_valid, sample_b_valid}, 32'd0);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, run_lvl, 0, 0, 0, '0);
    endtask

    task automatic wr(input bit ch, input logic [AW-1:0] d);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = !mpend[ch];
            step(1, run_lvl, 0, 1, ch, d);
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL ftw_write_timeout actual=0 expected=1 at %0t", $time);
        end
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 4 && mst != s; i++) step(1, run_lvl, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        run_lvl = 0;
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        idle(1);

        // Steady sweep: A steps 1 address per frame, B steps 2
        wr(0, 32'h0040_0000);
        wr(1, 32'h0080_0000);
        idle(1);
        run_lvl = 1;
        idle(40);

        // Negative tuning word wraps 0 -> 1023 -> 1022
        do_reset();
        wr(0, 32'hFFC0_0000);
        idle(1);
        run_lvl = 1;
        idle(10);

        // Back-to-back writes to A mid-frame: second waits for the boundary
        do_reset();
        wr(0, 32'h0040_0000); wr(1, 32'h0080_0000); idle(1);
        run_lvl = 1;
        idle(5);
        wait_slot(1);
        wr(0, 32'h0100_0000);
        wr(0, 32'h0200_0000);
        idle(10);

        // run dropped during SLOT_A: frame completes, then parked
        wait_slot(1);
        run_lvl = 0;
        idle(10);

        // phase_clr pulse in SLOT_A zeroes both accumulators at the boundary
        run_lvl = 1;
        idle(6);
        wait_slot(1);
        step(1, 1, 1, 0, 0, '0);
        idle(6);

        // phase_clr while parked
        run_lvl = 0;
        idle(4);
        step(1, 0, 1, 0, 0, '0);
        run_lvl = 1;
        idle(6);

        // reset in SLOT_B aborts the frame
        wait_slot(2);
        do_reset();
`ifdef DDS_SCHED_PHASE_OFFSET_EN
        offset_a = 10'd256;
        run_lvl = 1;
        idle(4);
        run_lvl = 0;
        idle(4);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
`ifdef DDS_SCHED_PHASE_OFFSET_EN
            if ($urandom_range(0, 49) == 0) begin
                offset_a = PW'($urandom);
                offset_b = PW'($urandom);
            end
`endif
            run_lvl = ($urandom_range(0, 9) != 0);
            step(($urandom_range(0, 299) != 0), run_lvl, ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom);
        end

        run_lvl = 0;
        idle(10);
        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
